// File: rtl/core_seq.sv
// ---------------------------------------------------------------------------
// core_seq - multi-cycle control sequencer for the RV32I core.
//
// Walks one instruction at a time through fetch, decode, execute, optional
// data-memory access and writeback. Owns the PC, the retired-instruction
// counter and trap/halt reporting. The 3-bit state code is exported so the
// register file can key its read (3) and write (7) cycles off it.
//
// state | meaning
// ------+---------------------------------------------------------------
//   0   | IDLE       : parked; start clears trap info and resumes at pc
//   1   | FETCH      : imem_req high, waiting for imem_ready
//   2   | FETCH_WAIT : waiting for imem_rvalid (bus timeout applies)
//   3   | DECODE     : register-file operand read
//   4   | EXECUTE    : sample decoder/ALU results, pick next step or trap
//   5   | MEM        : dmem_req high, waiting for dmem_ready
//   6   | MEM_WAIT   : waiting for dmem_rvalid (bus timeout applies)
//   7   | WRITEBACK  : register-file write, pc update, retire pulse
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   start                         begin/resume execution (IDLE only)
//   state                         current sequencer state code
//   pc                            address of the current instruction
//   imem_req/ready/rvalid/rdata   instruction-fetch handshake
//   instr                         latched instruction word
//   is_load/is_store/halt_req     decoder flags, sampled in EXECUTE
//   branch_taken/branch_target    ALU redirect, sampled in EXECUTE
//   dmem_req/we/ready/rvalid      data-memory handshake
//   retire                        one-cycle pulse per completed instruction
//   instret                       retired-instruction count (wraps)
//   halted, cause                 trap status (1 halt_req, 2 timeout, 3 misaligned)
// ---------------------------------------------------------------------------
module core_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        halt_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  cause
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_DECODE     = 3'd3,
    S_EXECUTE    = 3'd4,
    S_MEM        = 3'd5,
    S_MEM_WAIT   = 3'd6,
    S_WRITEBACK  = 3'd7
  } state_t;

  localparam logic [1:0] CAUSE_HALT    = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_ALIGN   = 2'd3;

  // Trap fires when the counter is on its last allowed cycle without valid,
  // i.e. after exactly TIMEOUT cycles spent in the wait state.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        load_q;
  logic        store_q;
  logic        taken_q;
  logic [31:0] target_q;
  logic [31:0] instret_q;
  logic        halted_q;
  logic [1:0]  cause_q;
  logic [15:0] wait_cnt_q;

  logic        latch_instr;
  logic        latch_exec;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        trap_clr;
  logic        commit;
  logic        wait_expired;

  assign wait_expired = (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    retire      = 1'b0;
    latch_instr = 1'b0;
    latch_exec  = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    trap        = 1'b0;
    trap_cause  = 2'd0;
    trap_clr    = 1'b0;
    commit      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          trap_clr = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          cnt_clr = 1'b1;
          state_d = S_FETCH_WAIT;
        end
      end

      S_FETCH_WAIT: begin
        if (imem_rvalid) begin
          latch_instr = 1'b1;
          state_d     = S_DECODE;
        end else begin
          cnt_inc = 1'b1;
          if (wait_expired) begin
            trap       = 1'b1;
            trap_cause = CAUSE_TIMEOUT;
            state_d    = S_IDLE;
          end
        end
      end

      S_DECODE: begin
        state_d = S_EXECUTE;
      end

      S_EXECUTE: begin
        latch_exec = 1'b1;
        if (halt_req) begin
          trap       = 1'b1;
          trap_cause = CAUSE_HALT;
          state_d    = S_IDLE;
        end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
          trap       = 1'b1;
          trap_cause = CAUSE_ALIGN;
          state_d    = S_IDLE;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = store_q;
        if (dmem_ready) begin
          // A store completes on acceptance; a load still needs its data.
          if (store_q) begin
            state_d = S_WRITEBACK;
          end else begin
            cnt_clr = 1'b1;
            state_d = S_MEM_WAIT;
          end
        end
      end

      S_MEM_WAIT: begin
        if (dmem_rvalid) begin
          state_d = S_WRITEBACK;
        end else begin
          cnt_inc = 1'b1;
          if (wait_expired) begin
            trap       = 1'b1;
            trap_cause = CAUSE_TIMEOUT;
            state_d    = S_IDLE;
          end
        end
      end

      S_WRITEBACK: begin
        retire  = 1'b1;
        commit  = 1'b1;
        state_d = S_FETCH;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= 32'd0;
      instret_q  <= 32'd0;
      halted_q   <= 1'b0;
      cause_q    <= 2'd0;
      wait_cnt_q <= 16'd0;
    end else begin
      if (latch_instr) begin
        instr_q <= imem_rdata;
      end

      if (latch_exec) begin
        load_q   <= is_load;
        store_q  <= is_store;
        taken_q  <= branch_taken;
        target_q <= branch_target;
      end

      if (cnt_clr) begin
        wait_cnt_q <= 16'd0;
      end else if (cnt_inc) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end

      if (trap_clr) begin
        halted_q <= 1'b0;
        cause_q  <= 2'd0;
      end else if (trap) begin
        halted_q <= 1'b1;
        cause_q  <= trap_cause;
      end

      // pc only moves on commit, so a trapped instruction leaves pc on itself.
      if (commit) begin
        pc_q      <= taken_q ? target_q : (pc_q + 32'd4);
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign state   = state_q;
  assign pc      = pc_q;
  assign instr   = instr_q;
  assign instret = instret_q;
  assign halted  = halted_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_core_seq.sv
module tb_core_seq;

  localparam int unsigned TO = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  state;
  logic [31:0] pc;
  logic        imem_req;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        is_load;
  logic        is_store;
  logic        halt_req;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic        retire;
  logic [31:0] instret;
  logic        halted;
  logic [1:0]  cause;

  core_seq #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .pc(pc),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr), .is_load(is_load), .is_store(is_store),
    .halt_req(halt_req), .branch_taken(branch_taken), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .retire(retire), .instret(instret),
    .halted(halted), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] next_pc;
    logic [31:0] count;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errs = 0;
  int          retire_cnt = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  always @(negedge clk) begin
    if (rst) retire_cnt = 0;
    else if (retire === 1'b1) retire_cnt = retire_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = 32'd0;
    is_load = 0; is_store = 0; halt_req = 0; branch_taken = 0;
    branch_target = 32'd0; dmem_ready = 0; dmem_rvalid = 0;
  endtask

  // Entered while in FETCH; leaves the DUT in DECODE.
  task automatic fetch(input logic [31:0] word, input int fdly, input int rdly);
    chk("fetch_state", state, 32'd1);
    chk("fetch_pc", pc, m_pc);
    chk("fetch_req", imem_req, 32'd1);
    repeat (fdly) begin
      tick();
      chk("fetch_hold_state", state, 32'd1);
      chk("fetch_hold_pc", pc, m_pc);
    end
    imem_ready = 1; tick(); imem_ready = 0;
    chk("fwait_state", state, 32'd2);
    chk("fwait_req_low", imem_req, 32'd0);
    repeat (rdly) begin
      tick();
      chk("fwait_hold_state", state, 32'd2);
    end
    imem_rvalid = 1; imem_rdata = word; tick();
    imem_rvalid = 0; imem_rdata = 32'hDEAD_BEEF;
    chk("decode_state", state, 32'd3);
    chk("decode_instr", instr, word);
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
    chk("start_state", state, 32'd1);
    chk("start_halted", halted, 32'd0);
    chk("start_cause", cause, 32'd0);
    chk("start_pc", pc, m_pc);
  endtask

  task automatic run_instr(input logic [31:0] word, input int fdly, input int rdly,
                           input bit ld, input bit st, input bit br,
                           input logic [31:0] tgt, input int mwait);
    exp_t e, got;
    e.pc = m_pc; e.word = word; e.next_pc = br ? tgt : m_pc + 32'd4; e.count = m_instret + 32'd1;
    sb.push_back(e);
    fetch(word, fdly, rdly);
    tick();
    chk("exec_state", state, 32'd4);
    is_load = ld; is_store = st; branch_taken = br; branch_target = tgt;
    tick();
    is_load = 0; is_store = 0; branch_taken = 0; branch_target = 32'd0;
    if (ld || st) begin
      chk("mem_state", state, 32'd5);
      chk("mem_req", dmem_req, 32'd1);
      chk("mem_we", dmem_we, {31'd0, st});
      dmem_ready = 1; tick(); dmem_ready = 0;
      if (ld) begin
        chk("mwait_state", state, 32'd6);
        chk("mwait_req_low", dmem_req, 32'd0);
        repeat (mwait) begin
          tick();
          chk("mwait_hold_state", state, 32'd6);
        end
        dmem_rvalid = 1; tick(); dmem_rvalid = 0;
      end
    end
    chk("wb_state", state, 32'd7);
    chk("wb_retire", retire, 32'd1);
    if (sb.size() == 0) begin
      chk("wb_scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("wb_pc", pc, got.pc);
      chk("wb_instr", instr, got.word);
      tick();
      chk("next_state", state, 32'd1);
      chk("next_pc", pc, got.next_pc);
      chk("instret", instret, got.count);
      chk("retire_low", retire, 32'd0);
      m_pc = got.next_pc;
      m_instret = got.count;
    end
  endtask

  task automatic run_trap(input logic [31:0] word, input bit hreq, input bit br,
                          input logic [31:0] tgt, input logic [1:0] exp_cause);
    fetch(word, 0, 0);
    tick();
    chk("trap_exec_state", state, 32'd4);
    halt_req = hreq; branch_taken = br; branch_target = tgt; is_load = 1;
    tick();
    halt_req = 0; branch_taken = 0; branch_target = 32'd0; is_load = 0;
    chk("trap_state", state, 32'd0);
    chk("trap_halted", halted, 32'd1);
    chk("trap_cause", cause, {30'd0, exp_cause});
    chk("trap_pc", pc, m_pc);
    chk("trap_retire", retire, 32'd0);
    chk("trap_instret", instret, m_instret);
    chk("trap_retire_cnt", retire_cnt, m_instret);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    start = 1;
    m_pc = RST_PC;
    m_instret = 32'd0;
    repeat (3) tick();
    chk("rst_state", state, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_imem_req", imem_req, 32'd0);
    chk("rst_dmem_req", dmem_req, 32'd0);
    chk("rst_dmem_we", dmem_we, 32'd0);
    chk("rst_retire", retire, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_halted", halted, 32'd0);
    chk("rst_cause", cause, 32'd0);
    rst = 0; start = 0;
    tick();
    chk("idle_after_rst", state, 32'd0);

    // Three plain ALU instructions.
    do_start();
    run_instr(32'h0000_0013, 1, 1, 0, 0, 0, 32'd0, 0);
    run_instr(32'h0010_0093, 0, 0, 0, 0, 0, 32'd0, 0);
    run_instr(32'h0020_0113, 2, 0, 0, 0, 0, 32'd0, 0);
    chk("alu_pc", pc, 32'h0000_000C);
    chk("alu_instret", instret, 32'd3);
    chk("alu_retire_cnt", retire_cnt, 32'd3);

    // Load with two MEM_WAIT cycles, then a store.
    run_instr(32'h0000_2183, 0, 0, 1, 0, 0, 32'd0, 1);
    run_instr(32'h0030_2023, 0, 0, 0, 1, 0, 32'd0, 0);
    chk("mem_instret", instret, 32'd5);

    // Aligned taken branch, then a misaligned one.
    run_instr(32'h0000_0063, 0, 0, 0, 0, 1, 32'h0000_0100, 0);
    chk("branch_pc", pc, 32'h0000_0100);
    run_trap(32'h0000_0463, 0, 1, 32'h0000_0102, 2'd3);
    do_start();

    // Fetch timeout: rvalid withheld for TO cycles.
    chk("to_state", state, 32'd1);
    imem_ready = 1; tick(); imem_ready = 0;
    chk("to_wait_state", state, 32'd2);
    repeat (TO - 1) begin
      tick();
      chk("to_wait_hold", state, 32'd2);
    end
    tick();
    chk("to_trap_state", state, 32'd0);
    chk("to_trap_cause", cause, 32'd2);
    chk("to_trap_halted", halted, 32'd1);
    chk("to_trap_pc", pc, m_pc);
    chk("to_trap_instret", instret, m_instret);
    do_start();

    // rvalid on exactly the last allowed cycle wins over the timeout.
    run_instr(32'h0040_0213, 0, TO - 1, 0, 0, 0, 32'd0, 0);
    chk("to_edge_pc", pc, 32'h0000_0104);

    // halt_req wins over a simultaneous load, then resume at the same pc.
    run_trap(32'h0000_0073, 1, 0, 32'd0, 2'd1);
    do_start();
    run_instr(32'h0050_0293, 0, 0, 0, 0, 0, 32'd0, 0);
    chk("resume_pc", pc, 32'h0000_0108);

    // Asynchronous reset in the middle of MEM_WAIT.
    fetch(32'h0000_2303, 0, 0);
    tick();
    is_load = 1; tick(); is_load = 0;
    dmem_ready = 1; tick(); dmem_ready = 0;
    chk("arst_pre_state", state, 32'd6);
    tick();
    chk("arst_pre_state2", state, 32'd6);
    #2 rst = 1;
    #1;
    chk("arst_state", state, 32'd0);
    chk("arst_pc", pc, RST_PC);
    chk("arst_dmem_req", dmem_req, 32'd0);
    chk("arst_instret", instret, 32'd0);
    chk("arst_halted", halted, 32'd0);
    tick();
    rst = 0;
    m_pc = RST_PC;
    m_instret = 32'd0;
    tick();
    chk("arst_idle", state, 32'd0);
    do_start();
    run_instr(32'h0060_0313, 0, 0, 0, 0, 0, 32'd0, 0);
    chk("post_rst_pc", pc, 32'h0000_0004);
    chk("post_rst_instret", instret, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
